btn_debounce: RTL and testbench
===============================

# btn_debounce

Two-channel push-button debouncer and press-pulse generator for the calculator front end. It consumes the two synchronised button bits from the two-bit input register stage (`q0`/`q1`), rejects contact bounce and emits a stable level plus a single-cycle press strobe per channel. The strobes drive the calculator's operand and operation control logic.

## Interface
Parameters:
- `DB_CYCLES`, 250000 — stable-sample count required to accept a level change (5 ms at 50 MHz); minimum 1.
- `CNT_W`, 18 — debounce counter width; must hold `DB_CYCLES-1`.
- `REPEAT_DELAY`, 25000000 — cycles from the entry pulse to the first repeat pulse (used only with `BTN_AUTO_REPEAT_EN`).
- `REPEAT_PERIOD`, 5000000 — cycles between later repeat pulses (used only with `BTN_AUTO_REPEAT_EN`).
- `RPT_W`, 25 — repeat counter width; must hold `max(REPEAT_DELAY, REPEAT_PERIOD)-1`.

Ports:
- `clk` input 1 — single clock; all state changes on the rising edge.
- `rst` input 1 — reset; synchronous, active-high.
- `d0` input 1 — channel 0 synchronised button bit, from the register stage `q0`.
- `d1` input 1 — channel 1 synchronised button bit, from the register stage `q1`.
- `lvl0` output 1 — channel 0 debounced level.
- `lvl1` output 1 — channel 1 debounced level.
- `press0` output 1 — channel 0 one-cycle press strobe.
- `press1` output 1 — channel 1 one-cycle press strobe.

## Operation
- The two channels are identical and fully independent. Each has its own FSM and counters.
- FSM states and transitions per channel:
  - IDLE (`lvl`=0): d=1 → ARM, cnt←0.
  - ARM (`lvl`=0): d=0 → IDLE, cnt←0. d=1 and cnt==`DB_CYCLES-1` → HELD, `lvl`←1, `press`←1. Otherwise cnt←cnt+1.
  - HELD (`lvl`=1): d=0 → DISARM, cnt←0.
  - DISARM (`lvl`=1): d=1 → HELD, with no press pulse. d=0 and cnt==`DB_CYCLES-1` → IDLE, `lvl`←0. Otherwise cnt←cnt+1.
- A level change is accepted after `DB_CYCLES+1` consecutive equal samples, counted from the first sample that differs from the current `lvl`.
- Any opposite sample during ARM or DISARM aborts the change and restarts the count from zero.
- `press` is high for exactly one cycle, on the cycle `lvl` becomes 1. Release produces no strobe.
- All outputs are registered; there is no combinational path from `d` to any output.
- Counters saturate by state transition only and never wrap.

## Timing
- All outputs are 0 during reset and on the first cycle after `rst` falls. All FSMs reset to IDLE and all counters reset to 0.
- `rst` dominates everything. Asserting it mid-debounce or mid-hold drops `lvl` and `press` at the next edge and suppresses any strobe due that edge.
- Press latency: `lvl` and `press` rise `DB_CYCLES+1` edges after the first high sample of an unbroken high run.
- Release latency: `lvl` falls `DB_CYCLES+1` edges after the first low sample of an unbroken low run.
- Both channels may strobe on the same cycle; there is no arbitration.

## Configuration
- `BTN_AUTO_REPEAT_EN` defined:
  - In HELD, a repeat counter runs. `press` additionally pulses `REPEAT_DELAY` cycles after the entry pulse, then every `REPEAT_PERIOD` cycles while HELD persists.
  - Leaving HELD clears the repeat counter.
  - Returning from DISARM to HELD restarts the `REPEAT_DELAY` wait, with no immediate pulse.
- `BTN_AUTO_REPEAT_EN` undefined: no repeat counter is instantiated, and `press` fires only on entry to HELD.

## Structure
- Shared package/header `btn_pkg` holds:
  - the 2-bit state encodings: IDLE=0, ARM=1, HELD=2, DISARM=3;
  - the default `DB_CYCLES` and repeat constants.
- Sub-module `debounce_ch` contains one channel: FSM, debounce counter and optional repeat counter.
- `btn_debounce` instantiates two `debounce_ch` instances and contains no other logic.

## Test plan
All scenarios use `DB_CYCLES`=4 unless noted.
1. Hold `rst`=1 for 2 cycles with d0=d1=1, then release → all outputs 0 during reset. `lvl0`/`lvl1` and `press0`/`press1` rise 5 edges after `rst` falls.
2. Raise d0 for 20 cycles, then drop it → `press0` is high for exactly 1 cycle at edge 5 and `lvl0` goes high at edge 5. `lvl0` falls 5 edges after d0 falls, and no strobe occurs on release.
3. Drive d0 with 1,1,0,1,1,1,1,1 → `lvl0` stays 0 through the first pair. It rises on the 5th consecutive high after the 0, with a single `press0` pulse.
4. While HELD, drive d0 low for 3 cycles, then high → `lvl0` stays 1 and `press0` stays 0 throughout.
5. Raise d0 and d1 on the same edge → `press0` and `press1` are asserted on the same cycle, 5 edges later.
6. With `BTN_AUTO_REPEAT_EN`, `REPEAT_DELAY`=10 and `REPEAT_PERIOD`=3, hold d0 for 30 cycles → `press0` pulses at entry E, then at E+10, E+13, E+16 and so on. Dropping d0 stops the pulses.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the two-channel push-button debouncer.
// Holds the per-channel FSM state encoding and the default timing constants
// used by debounce_ch and btn_debounce.
// No ports (package). Optional feature macro used by importers: BTN_AUTO_REPEAT_EN.
package btn_pkg;

  // Encodings are fixed; other blocks may decode the raw 2-bit value.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArm    = 2'd1,
    StHeld   = 2'd2,
    StDisarm = 2'd3
  } btn_state_e;

  // 5 ms at 50 MHz.
  localparam int unsigned DbCyclesDef     = 250000;
  localparam int unsigned CntWDef         = 18;
  // 0.5 s to first repeat, then 0.1 s between repeats, at 50 MHz.
  localparam int unsigned RepeatDelayDef  = 25000000;
  localparam int unsigned RepeatPeriodDef = 5000000;
  localparam int unsigned RptWDef         = 25;

endpackage

// File: rtl/debounce_ch.sv
// One debouncer channel: four-state FSM, debounce counter and, when the
// BTN_AUTO_REPEAT_EN macro is defined, a repeat counter that re-fires the
// press strobe while the button stays held.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   d     - synchronised button bit
//   lvl   - registered debounced level
//   press - registered one-cycle press strobe
module debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DbCyclesDef,
  parameter int unsigned CNT_W         = CntWDef,
  parameter int unsigned REPEAT_DELAY  = RepeatDelayDef,
  parameter int unsigned REPEAT_PERIOD = RepeatPeriodDef,
  parameter int unsigned RPT_W         = RptWDef
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic press
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             press_q, press_d;

`ifdef BTN_AUTO_REPEAT_EN
  logic [RPT_W-1:0] rpt_q, rpt_d;
  // Set while waiting for the first repeat after entering HELD.
  logic             first_q, first_d;
  logic [RPT_W-1:0] rpt_max;

  assign rpt_max = first_q ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_PERIOD - 1);
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD, RPT_W};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    press_d = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
    rpt_d   = rpt_q;
    first_d = first_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (d) begin
          state_d = StArm;
          cnt_d   = '0;
        end
      end
      StArm: begin
        if (!d) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StHeld;
          cnt_d   = '0;
          lvl_d   = 1'b1;
          press_d = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
          rpt_d   = '0;
          first_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StHeld: begin
        if (!d) begin
          state_d = StDisarm;
          cnt_d   = '0;
`ifdef BTN_AUTO_REPEAT_EN
          rpt_d   = '0;
`endif
        end
`ifdef BTN_AUTO_REPEAT_EN
        else if (rpt_q == rpt_max) begin
          press_d = 1'b1;
          rpt_d   = '0;
          first_d = 1'b0;
        end else begin
          rpt_d = rpt_q + RPT_W'(1);
        end
`endif
      end
      StDisarm: begin
        if (d) begin
          // Bounce back to held: no strobe, and the repeat wait starts over.
          state_d = StHeld;
          cnt_d   = '0;
`ifdef BTN_AUTO_REPEAT_EN
          rpt_d   = '0;
          first_d = 1'b1;
`endif
        end else if (cnt_q == CntMax) begin
          state_d = StIdle;
          cnt_d   = '0;
          lvl_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        lvl_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      rpt_q   <= rpt_d;
      first_q <= first_d;
    end
  end
`endif

  assign lvl   = lvl_q;
  assign press = press_q;

endmodule

// File: rtl/btn_debounce.sv
// Two-channel push-button debouncer and press-pulse generator for the
// calculator front end. Each channel is an independent debounce_ch.
// Optional auto-repeat of the press strobe: define BTN_AUTO_REPEAT_EN.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   d0/d1  - synchronised button bits (from register stage q0/q1)
//   lvl0/1 - debounced levels
//   press0/1 - one-cycle press strobes
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DbCyclesDef,
  parameter int unsigned CNT_W         = CntWDef,
  parameter int unsigned REPEAT_DELAY  = RepeatDelayDef,
  parameter int unsigned REPEAT_PERIOD = RepeatPeriodDef,
  parameter int unsigned RPT_W         = RptWDef
) (
  input  logic clk,
  input  logic rst,
  input  logic d0,
  input  logic d1,
  output logic lvl0,
  output logic lvl1,
  output logic press0,
  output logic press1
);

  debounce_ch #(
    .DB_CYCLES    (DB_CYCLES),
    .CNT_W        (CNT_W),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .RPT_W        (RPT_W)
  ) u_ch0 (
    .clk  (clk),
    .rst  (rst),
    .d    (d0),
    .lvl  (lvl0),
    .press(press0)
  );

  debounce_ch #(
    .DB_CYCLES    (DB_CYCLES),
    .CNT_W        (CNT_W),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .RPT_W        (RPT_W)
  ) u_ch1 (
    .clk  (clk),
    .rst  (rst),
    .d    (d1),
    .lvl  (lvl1),
    .press(press1)
  );

endmodule

// File: tb/tb_btn_debounce.sv
// Directed self-checking bench for btn_debounce with DB_CYCLES=4.
// Expected vectors are {lvl1, press1, lvl0, press0} after each rising edge.
module tb_btn_debounce;

  localparam int unsigned DbCycles     = 4;
  localparam int unsigned CntW         = 3;
  localparam int unsigned RepeatDelay  = 10;
  localparam int unsigned RepeatPeriod = 3;
  localparam int unsigned RptW         = 4;
`ifdef BTN_AUTO_REPEAT_EN
  localparam bit Rpt = 1'b1;
`else
  localparam bit Rpt = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, d0, d1;
  logic lvl0, lvl1, press0, press1;

  int checks = 0;
  int errors = 0;

  btn_debounce #(
    .DB_CYCLES    (DbCycles),
    .CNT_W        (CntW),
    .REPEAT_DELAY (RepeatDelay),
    .REPEAT_PERIOD(RepeatPeriod),
    .RPT_W        (RptW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .d0    (d0),
    .d1    (d1),
    .lvl0  (lvl0),
    .lvl1  (lvl1),
    .press0(press0),
    .press1(press1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  // Apply inputs, advance one edge, compare {lvl1,press1,lvl0,press0}.
  task automatic cyc(input string tag, input logic r, input logic a0, input logic a1,
                     input logic [3:0] exp);
    rst = r;
    d0  = a0;
    d1  = a1;
    @(posedge clk);
    #1;
    check(tag, {4'b0, lvl1, press1, lvl0, press0}, {4'b0, exp});
  endtask

  initial begin
    rst = 1'b1;
    d0  = 1'b1;
    d1  = 1'b1;

    // Reset with buttons held, then release: rise 5 edges later.
    cyc("rst_a", 1, 1, 1, 4'b0000);
    cyc("rst_b", 1, 1, 1, 4'b0000);
    for (int k = 1; k <= 4; k++) cyc("s1_wait", 0, 1, 1, 4'b0000);
    cyc("s1_e5", 0, 1, 1, 4'b1111);
    cyc("s1_e6", 0, 1, 1, 4'b1010);

    // Reset mid-hold drops the levels.
    cyc("rst_hold", 1, 1, 1, 4'b0000);
    cyc("rst_low", 1, 0, 0, 4'b0000);

    // Reset on the edge a strobe would be due suppresses it.
    for (int k = 1; k <= 4; k++) cyc("rst_due_wait", 0, 1, 0, 4'b0000);
    cyc("rst_due", 1, 1, 0, 4'b0000);
    cyc("rst_clr", 1, 0, 0, 4'b0000);
    cyc("idle_a", 0, 0, 0, 4'b0000);
    cyc("idle_b", 0, 0, 0, 4'b0000);

    // Scenario 2: hold d0 for 20 cycles, then release.
    for (int k = 1; k <= 4; k++) cyc("s2_wait", 0, 1, 0, 4'b0000);
    cyc("s2_e5", 0, 1, 0, 4'b0011);
    for (int k = 6; k <= 20; k++) begin
      logic p;
      p = Rpt && ((k - 5) == 10 || (k - 5) == 13);
      cyc("s2_hold", 0, 1, 0, {3'b001, p});
    end
    for (int k = 1; k <= 4; k++) cyc("s2_rel_wait", 0, 0, 0, 4'b0010);
    cyc("s2_rel_e5", 0, 0, 0, 4'b0000);
    for (int k = 1; k <= 3; k++) cyc("s2_idle", 0, 0, 0, 4'b0000);

    // Scenario 3: 1,1,0,1,1,1,1,1 on d0.
    cyc("s3_1", 0, 1, 0, 4'b0000);
    cyc("s3_2", 0, 1, 0, 4'b0000);
    cyc("s3_3", 0, 0, 0, 4'b0000);
    for (int k = 4; k <= 7; k++) cyc("s3_run", 0, 1, 0, 4'b0000);
    cyc("s3_8", 0, 1, 0, 4'b0011);
    cyc("s3_9", 0, 1, 0, 4'b0010);

    // Scenario 4: low glitch of 3 cycles while held, then high again.
    for (int k = 1; k <= 3; k++) cyc("s4_low", 0, 0, 0, 4'b0010);
    for (int k = 1; k <= 3; k++) cyc("s4_back", 0, 1, 0, 4'b0010);
    for (int k = 1; k <= 4; k++) cyc("s4_rel_wait", 0, 0, 0, 4'b0010);
    cyc("s4_rel_e5", 0, 0, 0, 4'b0000);

    // Scenario 5: both channels on the same edge.
    for (int k = 1; k <= 4; k++) cyc("s5_wait", 0, 1, 1, 4'b0000);
    cyc("s5_e5", 0, 1, 1, 4'b1111);
    cyc("s5_e6", 0, 1, 1, 4'b1010);
    for (int k = 1; k <= 4; k++) cyc("s5_rel_wait", 0, 0, 0, 4'b1010);
    cyc("s5_rel_e5", 0, 0, 0, 4'b0000);
    cyc("s5_idle", 0, 0, 0, 4'b0000);

`ifdef BTN_AUTO_REPEAT_EN
    // Scenario 6: entry at edge 5, repeats at E+10, E+13, E+16 ...
    for (int k = 1; k <= 4; k++) cyc("s6_wait", 0, 1, 0, 4'b0000);
    cyc("s6_entry", 0, 1, 0, 4'b0011);
    for (int j = 1; j <= 30; j++) begin
      logic p;
      p = (j >= 10) && (((j - 10) % 3) == 0);
      cyc("s6_hold", 0, 1, 0, {3'b001, p});
    end
    for (int k = 1; k <= 4; k++) cyc("s6_rel_wait", 0, 0, 0, 4'b0010);
    cyc("s6_rel_e5", 0, 0, 0, 4'b0000);
    for (int k = 1; k <= 12; k++) cyc("s6_stopped", 0, 0, 0, 4'b0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
